// File: rtl/reg_pipe_wb.sv
// reg_pipe_wb
//   Elastic valid/ready pipeline register between execute/memory and
//   write-back. It carries the WB payload: destination register, PC, memory
//   read data, ALU result, WB mux select and register-file write enable.
//   SKID=1 adds a second (skid) entry so in_ready comes only from flops.
//   SKID=0 keeps a single entry and in_ready follows out_ready
//   combinationally.
//   FLUSH squashes every held entry on the next edge.
//   stall_cnt counts back-pressure cycles and saturates at all-ones.
//
// Ports
//   CLK, RESET (async, active-high), FLUSH (sync squash)
//   in_valid / in_ready  : upstream handshake
//   in_WC .. in_W_RB     : incoming payload
//   out_valid / out_ready: downstream handshake
//   out_WC .. out_W_RB   : registered payload (out_W_RB gated by out_valid)
//   stall_cnt            : saturating count of out_valid & !out_ready cycles
module reg_pipe_wb #(
  parameter int WC_W        = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int SKID        = 1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   FLUSH,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WC_W-1:0]        in_WC,
  input  logic [ADDR_W-1:0]      in_PC,
  input  logic [DATA_W-1:0]      in_PR,
  input  logic [DATA_W-1:0]      in_alu_res,
  input  logic [1:0]             in_S_MXRB,
  input  logic                   in_W_RB,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WC_W-1:0]        out_WC,
  output logic [ADDR_W-1:0]      out_PC,
  output logic [DATA_W-1:0]      out_PR,
  output logic [DATA_W-1:0]      out_alu_res,
  output logic [1:0]             out_S_MXRB,
  output logic                   out_W_RB,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int PW = WC_W + ADDR_W + 2 * DATA_W + 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t          state;
  logic [PW-1:0]   in_data;
  logic [PW-1:0]   main_data;
  logic [PW-1:0]   skid_data;
  logic            started;
  logic            stored_w_rb;
  logic            accept;
  logic            take;

  assign in_data = {in_WC, in_PC, in_PR, in_alu_res, in_S_MXRB, in_W_RB};

  assign out_valid = (state != EMPTY);
  assign {out_WC, out_PC, out_PR, out_alu_res, out_S_MXRB, stored_w_rb} = main_data;
  // A bubble must never write the register file, whatever the payload holds.
  assign out_W_RB  = stored_w_rb & out_valid;

  assign accept = in_valid & in_ready;
  assign take   = out_valid & out_ready;

  // 'started' keeps in_ready low during reset and until the first edge after.
  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = started & (state != TWO);
    end else begin : g_noskid
      assign in_ready = started & ((state == EMPTY) | out_ready);
    end
  endgenerate

  // Occupancy FSM and payload registers. Payload moves only on a transfer.
  // With SKID=0 an accept in ONE implies a take, so the skid branch is
  // unreachable and TWO is never entered.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= EMPTY;
      main_data <= {PW{1'b0}};
      skid_data <= {PW{1'b0}};
      started   <= 1'b0;
    end else begin
      started <= 1'b1;
      if (FLUSH) begin
        state <= EMPTY;
      end else begin
        case (state)
          EMPTY: begin
            if (accept) begin
              main_data <= in_data;
              state     <= ONE;
            end
          end
          ONE: begin
            if (accept && take) begin
              main_data <= in_data;
            end else if (accept) begin
              skid_data <= in_data;
              state     <= TWO;
            end else if (take) begin
              state <= EMPTY;
            end
          end
          TWO: begin
            if (take) begin
              main_data <= skid_data;
              state     <= ONE;
            end
          end
          default: begin
            state <= EMPTY;
          end
        endcase
      end
    end
  end

  // Saturating back-pressure counter; only RESET clears it.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stall_cnt <= {STALL_CNT_W{1'b0}};
    end else if (out_valid && !out_ready && !FLUSH && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt <= stall_cnt;
    end
  end

endmodule

// File: tb/tb_reg_pipe_wb.sv
module tb_reg_pipe_wb;

  typedef struct packed {
    logic [3:0]  wc;
    logic [31:0] pc;
    logic [31:0] pr;
    logic [31:0] alu;
    logic [1:0]  mx;
    logic        wrb;
  } pl_t;

  logic        CLK;
  logic        RESET;
  logic        FLUSH;
  logic        in_valid;
  logic [3:0]  in_WC;
  logic [31:0] in_PC;
  logic [31:0] in_PR;
  logic [31:0] in_alu;
  logic [1:0]  in_mx;
  logic        in_wrb;
  logic        out_ready;

  // DUT 0: SKID=1, 16-bit counter
  logic        r0, ov0, wrb0;
  logic [3:0]  wc0;
  logic [31:0] pc0, pr0, alu0;
  logic [1:0]  mx0;
  logic [15:0] st0;
  // DUT 1: SKID=0, 4-bit counter
  logic        r1, ov1, wrb1;
  logic [3:0]  wc1;
  logic [31:0] pc1, pr1, alu1;
  logic [1:0]  mx1;
  logic [3:0]  st1;

  reg_pipe_wb #(.SKID(1), .STALL_CNT_W(16)) dut0 (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
    .in_valid(in_valid), .in_ready(r0),
    .in_WC(in_WC), .in_PC(in_PC), .in_PR(in_PR), .in_alu_res(in_alu),
    .in_S_MXRB(in_mx), .in_W_RB(in_wrb),
    .out_valid(ov0), .out_ready(out_ready),
    .out_WC(wc0), .out_PC(pc0), .out_PR(pr0), .out_alu_res(alu0),
    .out_S_MXRB(mx0), .out_W_RB(wrb0), .stall_cnt(st0)
  );

  reg_pipe_wb #(.SKID(0), .STALL_CNT_W(4)) dut1 (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
    .in_valid(in_valid), .in_ready(r1),
    .in_WC(in_WC), .in_PC(in_PC), .in_PR(in_PR), .in_alu_res(in_alu),
    .in_S_MXRB(in_mx), .in_W_RB(in_wrb),
    .out_valid(ov1), .out_ready(out_ready),
    .out_WC(wc1), .out_PC(pc1), .out_PR(pr1), .out_alu_res(alu1),
    .out_S_MXRB(mx1), .out_W_RB(wrb1), .stall_cnt(st1)
  );

  int   tests = 0;
  int   fails = 0;
  pl_t  q0[$];
  pl_t  q1[$];
  int   stm0 = 0;
  int   stm1 = 0;
  logic up;
  logic acc;
  logic sel;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // The stage may accept only after one clock edge has passed with RESET low.
  always @(posedge CLK or posedge RESET) begin
    if (RESET) up <= 1'b0;
    else       up <= 1'b1;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare one DUT against its scoreboard: the queue holds exactly the
  // entries the stage should currently be holding, oldest first.
  task automatic mon(input string tag, input bit skid, input logic rdy, input logic ov,
                     input logic [101:0] got, input logic gw, input int qs,
                     input pl_t front, input logic [15:0] st, input int st_exp);
    logic exp_rdy;
    exp_rdy = up && (skid ? (qs < 2) : ((qs == 0) || out_ready));
    chk({tag, "_out_valid"}, ov, qs != 0);
    chk({tag, "_in_ready"}, rdy, exp_rdy);
    chk({tag, "_out_W_RB"}, gw, (qs != 0) ? front.wrb : 1'b0);
    if (qs != 0) chk({tag, "_payload"}, got, front[102:1]);
    chk({tag, "_stall_cnt"}, st, st_exp[15:0]);
  endtask

  // Monitor for DUT 0.
  always @(negedge CLK) begin
    if (RESET) begin
      q0.delete();
      stm0 = 0;
    end else begin
      mon("skid1", 1'b1, r0, ov0, {wc0, pc0, pr0, alu0, mx0}, wrb0, q0.size(),
          (q0.size() != 0) ? q0[0] : pl_t'(0), st0, stm0);
      if (q0.size() != 0 && !out_ready && !FLUSH && stm0 < 65535) stm0 = stm0 + 1;
      if (FLUSH) q0.delete();
      else if (q0.size() != 0 && out_ready) void'(q0.pop_front());
    end
  end

  // Monitor for DUT 1.
  always @(negedge CLK) begin
    if (RESET) begin
      q1.delete();
      stm1 = 0;
    end else begin
      mon("skid0", 1'b0, r1, ov1, {wc1, pc1, pr1, alu1, mx1}, wrb1, q1.size(),
          (q1.size() != 0) ? q1[0] : pl_t'(0), {12'd0, st1}, stm1);
      if (q1.size() != 0 && !out_ready && !FLUSH && stm1 < 15) stm1 = stm1 + 1;
      if (FLUSH) q1.delete();
      else if (q1.size() != 0 && out_ready) void'(q1.pop_front());
    end
  end

  function automatic pl_t mk(input logic [3:0] wc, input logic [31:0] pc, input logic wrb);
    pl_t p;
    p.wc  = wc;
    p.pc  = pc;
    p.pr  = $urandom;
    p.alu = $urandom;
    p.mx  = 2'($urandom_range(0, 3));
    p.wrb = wrb;
    return p;
  endfunction

  task automatic set_pl(input pl_t p);
    in_WC  = p.wc;
    in_PC  = p.pc;
    in_PR  = p.pr;
    in_alu = p.alu;
    in_mx  = p.mx;
    in_wrb = p.wrb;
  endtask

  // One clock: record what each DUT accepts at the coming edge, then return
  // just after that edge so the caller can drive the next cycle's inputs.
  task automatic step();
    pl_t p;
    @(negedge CLK);
    #1;
    p = '{in_WC, in_PC, in_PR, in_alu, in_mx, in_wrb};
    if (!RESET && !FLUSH && in_valid) begin
      if (r0) q0.push_back(p);
      if (r1) q1.push_back(p);
    end
    acc = in_valid && (sel ? r1 : r0);
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input pl_t p);
    set_pl(p);
    in_valid = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (acc) break;
    end
    chk("send_timeout", acc, 1'b1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic stream(input logic s);
    sel = s;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(mk(4'(i), 32'h100 + 32'(4 * i), 1'b1));
    idle(3);
  endtask

  initial begin
    RESET = 1'b1; FLUSH = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0;
    set_pl('0);
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    idle(2);

    // Back-to-back streaming, SKID=1.
    stream(1'b0);

    // Back-pressure: two entries captured, then stalled, then drained.
    out_ready = 1'b0;
    send(mk(4'd1, 32'h200, 1'b1));
    send(mk(4'd2, 32'h204, 1'b0));
    set_pl(mk(4'd4, 32'h208, 1'b1));
    for (int k = 0; k < 4; k++) step();
    out_ready = 1'b1;
    idle(4);

    // Flush with the stage full and a valid input on the flush cycle.
    out_ready = 1'b0;
    send(mk(4'd3, 32'h300, 1'b1));
    send(mk(4'd5, 32'h304, 1'b1));
    set_pl(mk(4'd7, 32'h308, 1'b1));
    in_valid = 1'b1;
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    out_ready = 1'b1;
    send(mk(4'd9, 32'h30C, 1'b1));
    idle(3);

    // Bubble after a write-enabled entry drains.
    send(mk(4'd6, 32'h400, 1'b1));
    idle(3);

    // Long stall: 4-bit counter must stop at 15.
    out_ready = 1'b0;
    send(mk(4'd8, 32'h500, 1'b1));
    set_pl(mk(4'd10, 32'h504, 1'b1));
    for (int k = 0; k < 20; k++) step();
    chk("sat_stall_cnt", st1, 4'd15);
    out_ready = 1'b1;
    idle(4);

    // Asynchronous reset mid-transfer with all inputs driven nonzero.
    out_ready = 1'b0;
    set_pl('1);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) step();
    #2;
    RESET = 1'b1;
    #1;
    chk("rst_out_valid0", ov0, 1'b0);
    chk("rst_out_W_RB0", wrb0, 1'b0);
    chk("rst_payload0", {wc0, pc0, pr0, alu0, mx0}, 102'd0);
    chk("rst_stall0", st0, 16'd0);
    chk("rst_in_ready0", r0, 1'b0);
    chk("rst_out_valid1", ov1, 1'b0);
    chk("rst_payload1", {wc1, pc1, pr1, alu1, mx1}, 102'd0);
    chk("rst_stall1", st1, 4'd0);
    chk("rst_in_ready1", r1, 1'b0);
    step();
    step();
    RESET = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(2);
    chk("rst_release_ready0", r0, 1'b1);

    // Randomized traffic with occasional flushes.
    sel = 1'b0;
    for (int k = 0; k < 400; k++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      FLUSH = ($urandom_range(0, 15) == 0);
      if (!in_valid || acc)
        set_pl(mk(4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1))));
      in_valid = ($urandom_range(0, 3) != 0);
      step();
    end
    FLUSH = 1'b0;
    out_ready = 1'b1;
    idle(4);

    // Streaming again, pacing on the single-register instance.
    stream(1'b1);
    idle(2);
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_pipe_wb.md
# reg_pipe_wb

Parametrised, elastic pipeline register between the execute/memory stage and the write-back stage. It carries the write-back payload (destination register, PC, memory read data, ALU result, write-back mux select, register-file write enable) under a valid/ready handshake. An optional skid buffer breaks the combinational ready path, and a synchronous flush squashes in-flight instructions. A saturating counter records back-pressure cycles for performance analysis.

## Interface
Parameters:
- WC_W, 4, destination register index width
- ADDR_W, 32, PC width
- DATA_W, 32, width of PR and ALU result
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
- STALL_CNT_W, 16, stall counter width

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  asynchronous, active-high reset
- FLUSH  in  1  synchronous squash of all held entries
- in_valid  in  1  upstream payload valid
- in_ready  out  1  stage can accept this cycle
- in_WC  in  WC_W  destination register
- in_PC  in  ADDR_W  instruction PC
- in_PR  in  DATA_W  memory read data
- in_alu_res  in  DATA_W  ALU result
- in_S_MXRB  in  2  write-back mux select
- in_W_RB  in  1  register-file write enable
- out_valid  out  1  payload valid toward WB
- out_ready  in  1  WB consumes this cycle
- out_WC, out_PC, out_PR, out_alu_res, out_S_MXRB  out  as inputs  registered payload
- out_W_RB  out  1  equals stored W_RB AND out_valid
- stall_cnt  out  STALL_CNT_W  saturating back-pressure cycle count

## Operation
- Accept = in_valid & in_ready. Take = out_valid & out_ready.
- SKID=1: main register plus skid register; in_ready = !skid_valid (registered).
  - EMPTY (no entry): accept -> main <= in; go to ONE.
  - ONE: accept & take -> main <= in; stay ONE. Accept & !take -> skid <= in; go to TWO. !accept & take -> EMPTY. Neither -> hold.
  - TWO: in_ready=0. Take -> main <= skid; go to ONE. Otherwise hold.
- SKID=0: single register; in_ready = !out_valid | out_ready. Accept loads main; take without accept -> EMPTY.
- FLUSH: all valids cleared next edge -> EMPTY, regardless of accept/take in that cycle. An accepted input on a flush cycle is discarded. Payload registers need not be cleared.
- out_W_RB is gated by out_valid, so bubbles never write the register file.
- Payload registers load only on transfer; otherwise they hold. No payload changes while out_valid & !out_ready.
- stall_cnt increments each cycle with out_valid & !out_ready & !FLUSH. It saturates at all-ones and clears only on RESET.

## Timing
- RESET asserted: all outputs and state go to 0 immediately (out_valid=0, out_W_RB=0, all payloads 0, stall_cnt=0, state EMPTY). in_ready is 0 while RESET is high, and 1 in the first cycle after deassertion.
- Latency: accepted payload appears on outputs one cycle later when the stage is EMPTY or taking that cycle.
- Throughput: one transfer per cycle with out_ready held high in both modes.
- SKID=1: in_ready falls the cycle after the second entry is captured and rises the cycle after a take from TWO. No combinational path from out_ready to in_ready.
- RESET mid-transfer: held entries are lost and no output is valid until a new accept.
- FLUSH and RESET together: RESET dominates.

## Test plan
- Reset: drive all inputs nonzero, assert RESET asynchronously between edges -> outputs 0 immediately; in_ready=1 one cycle after release.
- Streaming, SKID=1: 8 back-to-back payloads PC=0x100..0x11C with out_ready=1 -> outputs in order, one per cycle, latency 1, in_ready stays 1.
- Back-pressure: hold out_ready=0 with in_valid=1 -> two entries accepted, then in_ready=0, stall_cnt increments each cycle. Release -> both entries drain in order, with no loss or duplication.
- Flush: stage in TWO (WC=3, WC=5), assert FLUSH with in_valid=1 -> next cycle out_valid=0, out_W_RB=0, accepted input dropped; next accept is delivered normally.
- Bubble gating: in_W_RB=1 stored, then take without new accept -> out_valid=0 and out_W_RB=0 although the payload register still holds W_RB=1.
- Saturation, STALL_CNT_W=4: stall 20 cycles -> stall_cnt=15 and holds. Repeat streaming with SKID=0 -> identical data ordering.
